// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: bubble instruction, fetch FSM states
// and the PC increment helper used by the fetch stage and the IF/ID register.
package riscv_pkg;

    // addi x0,x0,0 -- the canonical bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    // Sequential PC; wraps modulo 2^32
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave). A transfer completes in the cycle where
// imem_req and imem_rvalid are both high.
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush beats stall beats load; a bubble load
// forces the bubble instruction so decode never sees stale data.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic        load_valid,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic [31:0] instr_q,
    output logic [31:0] pc_q,
    output logic [31:0] pcplus4_q,
    output logic        valid_q
);

    // Register update: flush clears to bubble, stall holds, otherwise load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= 32'd0;
            pcplus4_q <= 32'd0;
            valid_q   <= 1'b0;
        end else if (flush) begin
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
        end else if (!stall) begin
            instr_q   <= load_valid ? load_instr : NOP_INSTR;
            pc_q      <= load_pc;
            pcplus4_q <= pc_inc(load_pc);
            valid_q   <= load_valid;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: PC register, fetch FSM with a one-word
// hold buffer, and the IF/ID register.
// FETCH  : request pc_F; a response either goes to IF/ID, into the hold
//          buffer (stall), or is discarded (redirect).
// HOLD   : a response arrived while stalled; no request until released.
// DROP   : a redirect arrived while a request was pending; the address is
//          held until the old response arrives, which is then thrown away.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched, perf_bubble and
// perf_drop event counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_F,
    input  logic                 stall_D,
    input  logic                 flush_D,
    input  logic                 pcsrc_E,
    input  logic [31:0]          pctarget_E,
    fetch_stage_if.master        imem,
    output logic [31:0]          instr_D,
    output logic [31:0]          pc_D,
    output logic [31:0]          pcplus4_D,
    output logic                 valid_D
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_bubble,
    output logic [31:0]          perf_drop
`endif
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  buf_reg, buf_next;
    logic [31:0]  buf_pc_reg, buf_pc_next;
    logic [31:0]  redirect_pc_reg, redirect_pc_next;

    logic         cand_valid;
    logic [31:0]  cand_instr;
    logic [31:0]  cand_pc;
    logic         fire;

    // Request is withdrawn only while a stalled response sits in the buffer
    assign imem.imem_req  = (state_reg != HOLD);
    assign imem.imem_addr = pc_reg;
    assign fire           = imem.imem_req & imem.imem_rvalid;

    // State, PC, hold buffer and pending redirect target
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= FETCH;
            pc_reg          <= RESET_PC;
            buf_reg         <= 32'd0;
            buf_pc_reg      <= 32'd0;
            redirect_pc_reg <= 32'd0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            buf_reg         <= buf_next;
            buf_pc_reg      <= buf_pc_next;
            redirect_pc_reg <= redirect_pc_next;
        end
    end

    // Next-state logic and the IF/ID candidate (bubble unless stated)
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        buf_next         = buf_reg;
        buf_pc_next      = buf_pc_reg;
        redirect_pc_next = redirect_pc_reg;
        cand_valid       = 1'b0;
        cand_instr       = NOP_INSTR;
        cand_pc          = pc_reg;

        case (state_reg)
            FETCH: begin
                if (fire) begin
                    if (pcsrc_E) begin
                        pc_next = pctarget_E;
                    end else if (stall_F) begin
                        buf_next    = imem.imem_rdata;
                        buf_pc_next = pc_reg;
                        pc_next     = pc_inc(pc_reg);
                        state_next  = HOLD;
                    end else begin
                        cand_valid = 1'b1;
                        cand_instr = imem.imem_rdata;
                        pc_next    = pc_inc(pc_reg);
                    end
                end else if (pcsrc_E) begin
                    redirect_pc_next = pctarget_E;
                    state_next       = DROP;
                end
            end
            HOLD: begin
                if (pcsrc_E) begin
                    pc_next    = pctarget_E;
                    state_next = FETCH;
                end else if (!stall_F) begin
                    cand_valid = 1'b1;
                    cand_instr = buf_reg;
                    cand_pc    = buf_pc_reg;
                    state_next = FETCH;
                end
            end
            DROP: begin
                if (fire) begin
                    pc_next    = pcsrc_E ? pctarget_E : redirect_pc_reg;
                    state_next = FETCH;
                end else if (pcsrc_E) begin
                    redirect_pc_next = pctarget_E;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush_D),
        .stall      (stall_D),
        .load_valid (cand_valid),
        .load_instr (cand_instr),
        .load_pc    (cand_pc),
        .instr_q    (instr_D),
        .pc_q       (pc_D),
        .pcplus4_q  (pcplus4_D),
        .valid_q    (valid_D)
    );

`ifdef FETCH_PERF_CNT_EN
    logic ifid_load;
    logic wait_event;
    logic drop_event;

    assign ifid_load  = !flush_D && !stall_D;
    assign wait_event = (state_reg == FETCH) && !fire && !pcsrc_E;
    assign drop_event = (fire && ((state_reg == DROP) || ((state_reg == FETCH) && pcsrc_E)))
                     || ((state_reg == HOLD) && pcsrc_E);

    // Wrapping event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_bubble  <= 32'd0;
            perf_drop    <= 32'd0;
        end else begin
            if (ifid_load && cand_valid) perf_fetched <= perf_fetched + 32'd1;
            if (ifid_load && wait_event) perf_bubble  <= perf_bubble + 32'd1;
            if (drop_event)              perf_drop    <= perf_drop + 32'd1;
        end
    end
`endif

endmodule
